// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Brief    : Two-producer in-order write-back FIFO that drains one result per
//            cycle into the register file write port and flags pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     mem_ready,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    input  logic [4:0]               chk_reg1,
    input  logic [4:0]               chk_reg2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic [CW-1:0]    w_free;
    logic             w_mem_push;
    logic             w_alu_push;
    logic             w_pop;
    logic [1:0]       w_pushes;
    logic [PW-1:0]    w_alu_slot;
    logic [DEPTH-1:0] w_live;

    // Readiness uses start-of-cycle occupancy only; a same-cycle pop gives no credit.
    assign w_free    = C_DEPTH - r_count;
    assign mem_ready = RESET && (w_free >= CW'(1));
    assign alu_ready = RESET && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !mem_valid));

    // x0 offers complete the handshake but never occupy a slot.
    assign w_mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign w_pop      = (r_count != '0);
    assign w_pushes   = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    assign w_alu_slot = r_tail + PW'(w_mem_push);
    assign count      = r_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= 5'd0;
            WriteData <= 32'd0;
        end else begin
            r_tail   <= r_tail + PW'(w_pushes);
            r_head   <= r_head + PW'(w_pop);
            r_count  <= r_count + CW'(w_pushes) - CW'(w_pop);
            RegWrite <= w_pop;
            if (w_pop) begin
                WriteReg  <= r_rd[r_head];
                WriteData <= r_data[r_head];
            end
        end
    end

    // Load is enqueued ahead of the ALU when both are accepted together.
    always_ff @(posedge CLK) begin
        if (w_mem_push) begin
            r_rd[r_tail]   <= mem_rd;
            r_data[r_tail] <= mem_data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_slot]   <= alu_rd;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
        logic [PW-1:0] w_off;
        assign w_off      = PW'(gi) - r_head;
        assign w_live[gi] = {1'b0, w_off} < r_count;
    end

    always_comb begin
        pending1 = 1'b0;
        pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] && (r_rd[i] == chk_reg1)) pending1 = 1'b1;
            if (w_live[i] && (r_rd[i] == chk_reg2)) pending2 = 1'b1;
        end
        if (RegWrite && (WriteReg == chk_reg1)) pending1 = 1'b1;
        if (RegWrite && (WriteReg == chk_reg2)) pending2 = 1'b1;
        if (chk_reg1 == 5'd0) pending1 = 1'b0;
        if (chk_reg2 == 5'd0) pending2 = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// Bench for regfile_writeback: queue-based reference model, per-cycle compare,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  chk_reg1 = '0, chk_reg2 = '0;
    logic        pending1, pending2;
    logic [$clog2(DEPTH):0] count;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .pending1(pending1), .pending2(pending2), .count(count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0]  q_rd[$];
    logic [31:0] q_d[$];
    logic        e_rw = 1'b0;
    logic [4:0]  e_wr = '0;
    logic [31:0] e_wd = '0;
    bit          acc_mem = 0, acc_alu = 0;
    bit          m_mr, m_ar;
    int          n_xfer = 0;
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut   [32];

    function automatic bit m_mem_ready();
        return RESET && ((DEPTH - q_rd.size()) >= 1);
    endfunction

    function automatic bit m_alu_ready();
        int free;
        free = DEPTH - q_rd.size();
        return RESET && ((free >= 2) || ((free >= 1) && !mem_valid));
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        bit hit;
        hit = 0;
        if (r == 5'd0) return 0;
        foreach (q_rd[i]) if (q_rd[i] == r) hit = 1;
        if (e_rw && e_wr == r) hit = 1;
        return hit;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_rd.delete();
            q_d.delete();
            e_rw = 0; e_wr = '0; e_wd = '0;
            acc_mem = 0; acc_alu = 0;
        end else begin
            m_mr = m_mem_ready();
            m_ar = m_alu_ready();
            acc_mem = mem_valid && m_mr;
            acc_alu = alu_valid && m_ar;
            if (q_rd.size() > 0) begin
                e_rw = 1;
                e_wr = q_rd.pop_front();
                e_wd = q_d.pop_front();
                rf_model[e_wr] = e_wd;
            end else begin
                e_rw = 0;
            end
            if (acc_mem) begin
                n_xfer++;
                if (mem_rd != 5'd0) begin q_rd.push_back(mem_rd); q_d.push_back(mem_data); end
            end
            if (acc_alu) begin
                n_xfer++;
                if (alu_rd != 5'd0) begin q_rd.push_back(alu_rd); q_d.push_back(alu_data); end
            end
        end
    end

    // The register file as seen by the core: whatever the DUT writes.
    always @(posedge CLK) if (RegWrite === 1'b1) rf_dut[WriteReg] = WriteData;

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        chk("count",     32'(count),     32'(q_rd.size()));
        chk("RegWrite",  32'(RegWrite),  32'(e_rw));
        chk("WriteReg",  32'(WriteReg),  32'(e_wr));
        chk("WriteData", WriteData,      e_wd);
        chk("mem_ready", 32'(mem_ready), 32'(m_mem_ready()));
        chk("alu_ready", 32'(alu_ready), 32'(m_alu_ready()));
        chk("pending1",  32'(pending1),  32'(m_pending(chk_reg1)));
        chk("pending2",  32'(pending2),  32'(m_pending(chk_reg2)));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [4:0] rand_rd(input bit allow0);
        return allow0 ? 5'($urandom_range(7)) : 5'($urandom_range(7, 1));
    endfunction

    // Producers hold an unaccepted offer; otherwise they may start a new one.
    task automatic drive(input int pm, input int pa, input bit allow0);
        if (!mem_valid || acc_mem) begin
            mem_valid = ($urandom_range(99) < pm);
            mem_rd    = rand_rd(allow0);
            mem_data  = $urandom();
        end
        if (!alu_valid || acc_alu) begin
            alu_valid = ($urandom_range(99) < pa);
            alu_rd    = rand_rd(allow0);
            alu_data  = $urandom();
        end
        chk_reg1 = 5'($urandom_range(7));
        chk_reg2 = 5'($urandom_range(7));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            @(negedge CLK); #1;
            drive(0, 0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int start, cyc, max_cnt, n_thr;

    initial begin
        foreach (rf_model[i]) begin rf_model[i] = '0; rf_dut[i] = '0; end

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_ready", 32'({alu_ready, mem_ready}), 32'd0);
        #1 RESET = 1'b1;

        // Single ALU write
        @(negedge CLK); #1;
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; chk_reg1 = 5'd5; chk_reg2 = 5'd3;
        @(negedge CLK);
        chk("single_pend_e1", 32'(pending1), 32'd1);
        chk("single_cnt_e1", 32'(count), 32'd1);
        chk("single_rw_e1", 32'(RegWrite), 32'd0);
        #1 alu_valid = 0;
        @(negedge CLK);
        chk("single_rw_e2", 32'(RegWrite), 32'd1);
        chk("single_wr_e2", 32'(WriteReg), 32'd5);
        chk("single_wd_e2", WriteData, 32'hDEADBEEF);
        chk("single_pend_e2", 32'(pending1), 32'd1);
        @(negedge CLK);
        chk("single_rw_e3", 32'(RegWrite), 32'd0);
        chk("single_pend_e3", 32'(pending1), 32'd0);
        chk("model_rf5", rf_model[5], 32'hDEADBEEF);

        // Simultaneous offers to the same register: load is older
        #1;
        mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h22;
        @(negedge CLK);
        chk("simul_cnt", 32'(count), 32'd2);
        chk("simul_pend2", 32'(pending2), 32'd1);
        #1 mem_valid = 0; alu_valid = 0;
        @(negedge CLK);
        chk("simul_first", WriteData, 32'h11);
        @(negedge CLK);
        chk("simul_second", WriteData, 32'h22);
        chk("simul_second_rw", 32'(RegWrite), 32'd1);
        @(negedge CLK);
        chk("simul_done_rw", 32'(RegWrite), 32'd0);
        chk("simul_rf3", rf_dut[3], 32'h22);
        chk("model_rf3", rf_model[3], 32'h22);

        // x0 drop
        #1;
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF; chk_reg1 = 5'd0;
        #1 chk("x0_ready", 32'(alu_ready), 32'd1);
        @(negedge CLK);
        chk("x0_acc", 32'(acc_alu), 32'd1);
        chk("x0_cnt", 32'(count), 32'd0);
        chk("x0_pend", 32'(pending1), 32'd0);
        #1 alu_valid = 0;
        @(negedge CLK);
        chk("x0_rw", 32'(RegWrite), 32'd0);

        // Backpressure: both producers valid every cycle
        start = n_xfer; max_cnt = 0; n_thr = 0; cyc = 0;
        #1 drive(100, 100, 1'b0);
        while (n_xfer < start + 20 && cyc < 200) begin
            @(negedge CLK);
            if (32'(count) > max_cnt) max_cnt = 32'(count);
            if (alu_valid && mem_valid && mem_ready && !alu_ready) n_thr++;
            #1 drive(100, 100, 1'b0);
            cyc++;
        end
        chk("burst_bound", 32'(cyc < 200), 32'd1);
        chk("burst_max_cnt", 32'(max_cnt), 32'(DEPTH - 1));
        chk("burst_throttled", 32'(n_thr > 0), 32'd1);
        @(negedge CLK);
        chk("burst_cnt", 32'(count), 32'(DEPTH - 1));

        // Asynchronous reset mid-burst
        #1 RESET = 1'b0;
        mem_valid = 0; alu_valid = 0; chk_reg1 = WriteReg; chk_reg2 = 5'd1;
        #1;
        chk("midrst_cnt", 32'(count), 32'd0);
        chk("midrst_rw", 32'(RegWrite), 32'd0);
        chk("midrst_wd", WriteData, 32'd0);
        chk("midrst_wr", 32'(WriteReg), 32'd0);
        chk("midrst_pend", 32'({pending1, pending2}), 32'd0);
        mem_valid = 1; alu_valid = 1; mem_rd = 5'd2; alu_rd = 5'd4;
        #1 chk("midrst_ready", 32'({alu_ready, mem_ready}), 32'd0);
        mem_valid = 0; alu_valid = 0;
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("postrst_rw", 32'(RegWrite), 32'd0);
            chk("postrst_cnt", 32'(count), 32'd0);
        end

        // Wrap-around: single-source transfers with random stalls
        start = n_xfer; cyc = 0;
        #1 drive(0, 60, 1'b0);
        while (n_xfer < start + 2 * DEPTH + 1 && cyc < 200) begin
            @(negedge CLK); #1;
            drive(0, 60, 1'b0);
            cyc++;
        end
        chk("wrap_bound", 32'(cyc < 200), 32'd1);
        drain();
        @(negedge CLK);
        chk("wrap_empty", 32'(count), 32'd0);

        // Randomized mixed traffic including x0 offers
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK); #1;
            drive(i % 3 == 0 ? 90 : 45, 55, 1'b1);
        end
        drain();
        @(negedge CLK);
        chk("final_empty", 32'(count), 32'd0);
        foreach (rf_dut[i]) chk("final_rf", rf_dut[i], rf_model[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
